// File: rtl/comparator_pkg.sv
// Shared encodings and helpers for the unsigned magnitude comparator.
// Result vectors are always ordered {gtr, eq, lt}.
package comparator_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef logic [2:0] cmp_res_t;

    // Packs the chain outputs into a result code. The slice chain already
    // yields at most one active flag, so priority order only matters as a
    // guard: an illegal multi-hot combination can never reach the register.
    function automatic cmp_res_t cmp_select(input logic gt, input logic eq, input logic lt);
        cmp_res_t res;
        if (gt) begin
            res = CMP_GT;
        end else if (eq) begin
            res = CMP_EQ;
        end else if (lt) begin
            res = CMP_LT;
        end else begin
            res = CMP_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/comparator_bit.sv
// Combinational 1-bit compare slice. A decision made by a more significant
// slice (gt_in/lt_in) passes straight through; only while everything above
// is still equal (eq_in) does this bit get a say.
module comparator_bit (
    input  logic a,
    input  logic b,
    input  logic gt_in,
    input  logic eq_in,
    input  logic lt_in,
    output logic gt_out,
    output logic eq_out,
    output logic lt_out
);

    assign eq_out = eq_in & ~(a ^ b);
    assign gt_out = gt_in | (eq_in & a & ~b);
    assign lt_out = lt_in | (eq_in & ~a & b);

endmodule

// File: rtl/comparator.sv
// Unsigned WIDTH-bit magnitude comparator with cascade enable e and a
// registered {gtr, eq, lt} result (one cycle latency). e=0 forces 000.
module comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             gtr,
    output logic             eq,
    output logic             lt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             e
);

    cmp_res_t res_s;
    cmp_res_t res_r;

    // Slice chain runs MSB to LSB; the MSB slice is seeded with "equal so
    // far" equal to e, so e=0 leaves every flag low all the way down.
    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        logic gt_in_s;
        logic eq_in_s;
        logic lt_in_s;
        logic gt_out_s;
        logic eq_out_s;
        logic lt_out_s;

        if (i == WIDTH - 1) begin : g_seed
            assign gt_in_s = 1'b0;
            assign eq_in_s = e;
            assign lt_in_s = 1'b0;
        end else begin : g_link
            assign gt_in_s = g_slice[i+1].gt_out_s;
            assign eq_in_s = g_slice[i+1].eq_out_s;
            assign lt_in_s = g_slice[i+1].lt_out_s;
        end

        comparator_bit u_bit (
            .a      (A[i]),
            .b      (B[i]),
            .gt_in  (gt_in_s),
            .eq_in  (eq_in_s),
            .lt_in  (lt_in_s),
            .gt_out (gt_out_s),
            .eq_out (eq_out_s),
            .lt_out (lt_out_s)
        );
    end

    assign res_s = cmp_select(g_slice[0].gt_out_s, g_slice[0].eq_out_s, g_slice[0].lt_out_s);

    // Result register: cleared immediately on reset, otherwise captures the chain every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= CMP_NONE;
        end else begin
            res_r <= res_s;
        end
    end

    assign gtr = res_r[2];
    assign eq  = res_r[1];
    assign lt  = res_r[0];

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: WIDTH=1, 4 and 8 instances plus a
// two-slice cascade of WIDTH=1 cells. Results are compared as {gtr,eq,lt}.
module tb_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       a1 = 1'b0, b1 = 1'b0, e1 = 1'b0;
    logic [2:0] q1;
    comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .gtr(q1[2]), .eq(q1[1]), .lt(q1[0]),
        .A(a1), .B(b1), .e(e1)
    );

    // WIDTH=4 instance
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       e4 = 1'b0;
    logic [2:0] q4;
    comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .gtr(q4[2]), .eq(q4[1]), .lt(q4[0]),
        .A(a4), .B(b4), .e(e4)
    );

    // WIDTH=8 instance
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       e8 = 1'b0;
    logic [2:0] q8;
    comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .gtr(q8[2]), .eq(q8[1]), .lt(q8[0]),
        .A(a8), .B(b8), .e(e8)
    );

    // Cascade: upper slice eq feeds lower slice e
    logic       ah = 1'b0, bh = 1'b0, al = 1'b0, bl = 1'b0, ec = 1'b0;
    logic [2:0] qh, ql;
    comparator #(.WIDTH(1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .gtr(qh[2]), .eq(qh[1]), .lt(qh[0]),
        .A(ah), .B(bh), .e(ec)
    );
    comparator #(.WIDTH(1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .gtr(ql[2]), .eq(ql[1]), .lt(ql[0]),
        .A(al), .B(bl), .e(qh[1])
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       e;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t v1 [6];
    vec_t v4 [8];

    function automatic logic [2:0] golden(input logic [7:0] a, input logic [7:0] b, input logic e);
        logic [2:0] r;
        if (!e)          r = 3'b000;
        else if (a > b)  r = 3'b100;
        else if (a == b) r = 3'b010;
        else             r = 3'b001;
        return r;
    endfunction

    initial begin
        // WIDTH=1 truth table (only bit 0 of a/b used)
        v1[0] = '{4'h0, 4'h0, 1'b0, 3'b000, "w1_000"};
        v1[1] = '{4'h0, 4'h0, 1'b1, 3'b010, "w1_001"};
        v1[2] = '{4'h0, 4'h1, 1'b0, 3'b000, "w1_010"};
        v1[3] = '{4'h0, 4'h1, 1'b1, 3'b001, "w1_011"};
        v1[4] = '{4'h1, 4'h0, 1'b1, 3'b100, "w1_101"};
        v1[5] = '{4'h1, 4'h1, 1'b1, 3'b010, "w1_111"};
        // WIDTH=4 extremes and MSB-first decisions
        v4[0] = '{4'hF, 4'h0, 1'b1, 3'b100, "w4_F_0"};
        v4[1] = '{4'h0, 4'hF, 1'b1, 3'b001, "w4_0_F"};
        v4[2] = '{4'h8, 4'h7, 1'b1, 3'b100, "w4_8_7"};
        v4[3] = '{4'h5, 4'h5, 1'b1, 3'b010, "w4_5_5"};
        v4[4] = '{4'h9, 4'h3, 1'b0, 3'b000, "w4_9_3_off"};
        v4[5] = '{4'h0, 4'h0, 1'b1, 3'b010, "w4_0_0"};
        v4[6] = '{4'hF, 4'hF, 1'b1, 3'b010, "w4_F_F"};
        v4[7] = '{4'h6, 4'h7, 1'b1, 3'b001, "w4_6_7"};

        // Reset state
        #1;
        check("reset_w1", q1, 3'b000);
        check("reset_w4", q4, 3'b000);
        check("reset_w8", q8, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a1 = v1[i].a[0]; b1 = v1[i].b[0]; e1 = v1[i].e;
            @(posedge clk); #1;
            check(v1[i].name, q1, v1[i].exp);
        end

        // WIDTH=4 table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a4 = v4[i].a; b4 = v4[i].b; e4 = v4[i].e;
            @(posedge clk); #1;
            check(v4[i].name, q4, v4[i].exp);
        end

        // Latency: A 0->1 with B=0,e=1 shows only after the next edge
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; e1 = 1'b1;
        @(posedge clk); #1;
        check("lat_pre", q1, 3'b010);
        @(negedge clk);
        a1 = 1'b1;
        #1;
        check("lat_before_edge", q1, 3'b010);
        @(posedge clk); #1;
        check("lat_after_edge", q1, 3'b100);

        // Reset mid-cycle clears at once and holds until release
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_immediate", q1, 3'b000);
        @(posedge clk); #1;
        check("rst_mid_held1", q1, 3'b000);
        @(posedge clk); #1;
        check("rst_mid_held2", q1, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_noedge", q1, 3'b000);
        @(posedge clk); #1;
        check("rst_first_result", q1, 3'b100);

        // Random WIDTH=8 against golden model
        for (int i = 0; i < 1000; i++) begin
            logic [2:0] exp8;
            @(negedge clk);
            a8 = 8'($urandom_range(0, 255));
            b8 = (($urandom_range(0, 7)) == 0) ? a8 : 8'($urandom_range(0, 255));
            e8 = ($urandom_range(0, 4) != 0);
            exp8 = golden(a8, b8, e8);
            @(posedge clk); #1;
            check("rand_w8", q8, exp8);
        end

        // Cascade 2-bit: 10 vs 01 -> upper gtr, lower idle
        @(negedge clk);
        ec = 1'b1; ah = 1'b1; al = 1'b0; bh = 1'b0; bl = 1'b1;
        @(posedge clk); #1;
        check("casc_10_01_hi", qh, 3'b100);
        @(posedge clk); #1;
        check("casc_10_01_lo", ql, 3'b000);

        // Cascade 2-bit: 11 vs 10 -> upper eq, lower gtr
        @(negedge clk);
        ah = 1'b1; al = 1'b1; bh = 1'b1; bl = 1'b0;
        @(posedge clk); #1;
        check("casc_11_10_hi", qh, 3'b010);
        @(posedge clk); #1;
        check("casc_11_10_lo", ql, 3'b100);

        // Cascade 2-bit: 01 vs 01 -> both eq
        @(negedge clk);
        ah = 1'b0; al = 1'b1; bh = 1'b0; bl = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("casc_01_01_hi", qh, 3'b010);
        check("casc_01_01_lo", ql, 3'b010);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
